// File: rtl/servant_ram_arbiter.sv
// rtl/servant_ram_arbiter.sv - two-master (ibus/dbus) RAM arbiter; define SERVANT_ARB_TIMEOUT_EN for grant timeout
module servant_ram_arbiter #(
    parameter int aw      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic [31:0]   i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [31:0]   i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    output logic [aw-3:0] o_ram_adr,
    output logic [31:0]   o_ram_dat,
    output logic [3:0]    o_ram_sel,
    output logic          o_ram_we,
    output logic          o_ram_cyc,
    input  logic [31:0]   i_ram_rdt,
    input  logic          i_ram_ack,
    output logic          o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   ibus_live;
    logic   dbus_live;
    logic   timeout_hit;
    logic   term_ack;

    // A grant only counts as live while its master still holds cyc
    assign ibus_live = (state == GNT_I) && i_ibus_cyc;
    assign dbus_live = (state == GNT_D) && i_dbus_cyc;

`ifdef SERVANT_ARB_TIMEOUT_EN
    logic [7:0] count;

    // Cycles spent in a grant without a RAM ack; restarts from zero in IDLE
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            count <= 8'd0;
        end else if (state == IDLE) begin
            count <= 8'd0;
        end else if (!i_ram_ack) begin
            count <= count + 8'd1;
        end
    end

    // A real ack on the last allowed cycle wins over the forced termination
    assign timeout_hit = (ibus_live || dbus_live) && !i_ram_ack
                         && (count == 8'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = &{1'b0, 8'(TIMEOUT)};
    assign timeout_hit    = 1'b0;
`endif

    assign term_ack  = i_ram_ack || timeout_hit;
    assign o_timeout = timeout_hit && !i_wb_rst;

    // Acks go only to the live granted master and never during reset
    assign o_ibus_ack = ibus_live && term_ack && !i_wb_rst;
    assign o_dbus_ack = dbus_live && term_ack && !i_wb_rst;

    // Read data passes through except on a forced termination, which returns zero
    assign o_ibus_rdt = (ibus_live && timeout_hit) ? 32'h0 : i_ram_rdt;
    assign o_dbus_rdt = (dbus_live && timeout_hit) ? 32'h0 : i_ram_rdt;

    // RAM cycle drops on reset and on the timeout cycle so no access completes
    assign o_ram_cyc = (ibus_live || dbus_live) && !timeout_hit && !i_wb_rst;

    // RAM request mux: dbus only when granted, otherwise a full-word ibus read
    always_comb begin
        o_ram_adr = i_ibus_adr[aw-1:2];
        o_ram_dat = 32'h0;
        o_ram_sel = 4'hF;
        o_ram_we  = 1'b0;
        if (state == GNT_D) begin
            o_ram_adr = i_dbus_adr[aw-1:2];
            o_ram_dat = i_dbus_dat;
            o_ram_sel = i_dbus_sel;
            o_ram_we  = i_dbus_we;
        end
    end

    // Next-state: round-robin on a tie, leave a grant on ack, timeout or abort
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_ibus_cyc && i_dbus_cyc) begin
                    state_nxt = last_grant ? GNT_I : GNT_D;
                end else if (i_ibus_cyc) begin
                    state_nxt = GNT_I;
                end else if (i_dbus_cyc) begin
                    state_nxt = GNT_D;
                end
            end
            GNT_I: begin
                if (!i_ibus_cyc || term_ack) begin
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                if (!i_dbus_cyc || term_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and record of which master was granted last
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GNT_I) begin
                last_grant <= 1'b0;
            end else if (state == IDLE && state_nxt == GNT_D) begin
                last_grant <= 1'b1;
            end
        end
    end

    logic unused;
    assign unused = &{1'b0, i_ibus_adr[31:aw], i_ibus_adr[1:0],
                      i_dbus_adr[31:aw], i_dbus_adr[1:0]};

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// tb/tb_servant_ram_arbiter.sv - directed self-checking bench for servant_ram_arbiter
module tb_servant_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ibus_adr = 32'h0;
    logic        ibus_cyc = 1'b0;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr = 32'h0;
    logic [31:0] dbus_dat = 32'h0;
    logic [3:0]  dbus_sel = 4'h0;
    logic        dbus_we  = 1'b0;
    logic        dbus_cyc = 1'b0;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [5:0]  ram_adr;
    logic [31:0] ram_dat;
    logic [3:0]  ram_sel;
    logic        ram_we;
    logic        ram_cyc;
    logic [31:0] ram_rdt = 32'h0;
    logic        ram_ack;
    logic        timeout;

    logic        ack_r = 1'b0;
    logic        ack_en = 1'b1;
    logic        ack_force = 1'b0;
    logic [31:0] mem [0:63];

    int passed = 0;
    int total  = 0;

    assign ram_ack = (ack_r && ack_en) || ack_force;

    always #5 clk = ~clk;

    servant_ram_arbiter #(.aw(8), .TIMEOUT(4)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst   (rst),
        .i_ibus_adr (ibus_adr),
        .i_ibus_cyc (ibus_cyc),
        .o_ibus_rdt (ibus_rdt),
        .o_ibus_ack (ibus_ack),
        .i_dbus_adr (dbus_adr),
        .i_dbus_dat (dbus_dat),
        .i_dbus_sel (dbus_sel),
        .i_dbus_we  (dbus_we),
        .i_dbus_cyc (dbus_cyc),
        .o_dbus_rdt (dbus_rdt),
        .o_dbus_ack (dbus_ack),
        .o_ram_adr  (ram_adr),
        .o_ram_dat  (ram_dat),
        .o_ram_sel  (ram_sel),
        .o_ram_we   (ram_we),
        .o_ram_cyc  (ram_cyc),
        .i_ram_rdt  (ram_rdt),
        .i_ram_ack  (ram_ack),
        .o_timeout  (timeout)
    );

    // Single-cycle-ack RAM with byte-lane writes
    always @(posedge clk) begin
        if (rst || !ack_en) begin
            ack_r <= 1'b0;
        end else if (ram_cyc && !ack_r) begin
            ack_r   <= 1'b1;
            ram_rdt <= mem[ram_adr];
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_sel[b]) mem[ram_adr][8*b +: 8] <= ram_dat[8*b +: 8];
                end
            end
        end else begin
            ack_r <= 1'b0;
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        ibus_adr = 32'h24;
        ibus_cyc = 1'b1;
        #1;
        total++; if (ram_cyc !== 1'b0) $display("FAIL reset_ram_cyc got %b exp 0", ram_cyc); else passed++;
        total++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) $display("FAIL reset_acks got %b%b exp 00", ibus_ack, dbus_ack); else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", timeout); else passed++;
        total++; if ({ram_we, ram_sel, ram_dat, ram_adr} !== {1'b0, 4'hF, 32'h0, 6'd9})
            $display("FAIL reset_idle_mux got we=%b sel=%h dat=%h adr=%0d exp we=0 sel=f dat=0 adr=9", ram_we, ram_sel, ram_dat, ram_adr);
        else passed++;
        ibus_cyc = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_ibus_read;
        ibus_adr = 32'h20;
        ibus_cyc = 1'b1;
        step();
        total++; if (ram_cyc !== 1'b1 || ram_adr !== 6'd8) $display("FAIL ibus_n1_cyc got cyc=%b adr=%0d exp cyc=1 adr=8", ram_cyc, ram_adr); else passed++;
        total++; if (ibus_ack !== 1'b0) $display("FAIL ibus_n1_ack got %b exp 0", ibus_ack); else passed++;
        step();
        total++; if (ibus_ack !== 1'b1 || ibus_rdt !== 32'h00100073) $display("FAIL ibus_n2_ack got ack=%b rdt=%h exp ack=1 rdt=00100073", ibus_ack, ibus_rdt); else passed++;
        total++; if (dbus_ack !== 1'b0) $display("FAIL ibus_n2_dbus_ack got %b exp 0", dbus_ack); else passed++;
        ibus_cyc = 1'b0;
        step();
        total++; if (ram_cyc !== 1'b0 || ibus_ack !== 1'b0) $display("FAIL ibus_n3_idle got cyc=%b ack=%b exp 0 0", ram_cyc, ibus_ack); else passed++;
    endtask

    task automatic test_dbus_write;
        dbus_adr = 32'h10;
        dbus_dat = 32'hA5A5A5A5;
        dbus_sel = 4'b0011;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        step();
        total++; if ({ram_cyc, ram_we, ram_sel, ram_dat, ram_adr} !== {1'b1, 1'b1, 4'b0011, 32'hA5A5A5A5, 6'd4})
            $display("FAIL dbus_wr_mux got cyc=%b we=%b sel=%h dat=%h adr=%0d exp 1 1 3 a5a5a5a5 4", ram_cyc, ram_we, ram_sel, ram_dat, ram_adr);
        else passed++;
        step();
        total++; if (dbus_ack !== 1'b1 || ibus_ack !== 1'b0) $display("FAIL dbus_wr_ack got d=%b i=%b exp d=1 i=0", dbus_ack, ibus_ack); else passed++;
        dbus_cyc = 1'b0;
        dbus_we  = 1'b0;
        step();
        ibus_adr = 32'h10;
        ibus_cyc = 1'b1;
        step();
        step();
        total++; if (ibus_ack !== 1'b1 || ibus_rdt !== 32'h0000A5A5) $display("FAIL dbus_wr_readback got ack=%b rdt=%h exp ack=1 rdt=0000a5a5", ibus_ack, ibus_rdt); else passed++;
        ibus_cyc = 1'b0;
        step();
    endtask

    task automatic test_abort;
        dbus_adr = 32'h14;
        dbus_dat = 32'hFFFFFFFF;
        dbus_sel = 4'hF;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        step();
        total++; if (ram_cyc !== 1'b1) $display("FAIL abort_granted got cyc=%b exp 1", ram_cyc); else passed++;
        dbus_cyc = 1'b0;
        #1;
        total++; if (ram_cyc !== 1'b0 || dbus_ack !== 1'b0) $display("FAIL abort_drop got cyc=%b ack=%b exp 0 0", ram_cyc, dbus_ack); else passed++;
        step();
        dbus_we = 1'b0;
        total++; if (dbus_ack !== 1'b0 || mem[5] !== 32'h0) $display("FAIL abort_no_write got ack=%b mem5=%h exp 0 00000000", dbus_ack, mem[5]); else passed++;
        ibus_adr = 32'h14;
        ibus_cyc = 1'b1;
        step();
        total++; if (ram_cyc !== 1'b1 || ram_we !== 1'b0) $display("FAIL abort_idle_next got cyc=%b we=%b exp 1 0", ram_cyc, ram_we); else passed++;
        step();
        total++; if (ibus_ack !== 1'b1 || ibus_rdt !== 32'h0) $display("FAIL abort_readback got ack=%b rdt=%h exp 1 00000000", ibus_ack, ibus_rdt); else passed++;
        ibus_cyc = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ibus_adr = 32'h10;
        ibus_cyc = 1'b1;
        dbus_adr = 32'h20;
        dbus_sel = 4'hF;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            total++; if (dbus_ack !== ((k % 6) == 2)) $display("FAIL alt_dbus_ack_c%0d got %b exp %b", k, dbus_ack, (k % 6) == 2); else passed++;
            total++; if (ibus_ack !== ((k % 6) == 5)) $display("FAIL alt_ibus_ack_c%0d got %b exp %b", k, ibus_ack, (k % 6) == 5); else passed++;
            if (k == 1) begin
                total++; if (ram_adr !== 6'd8) $display("FAIL alt_first_grant_d got adr=%0d exp 8", ram_adr); else passed++;
            end
            if (k == 4) begin
                total++; if (ram_adr !== 6'd4) $display("FAIL alt_second_grant_i got adr=%0d exp 4", ram_adr); else passed++;
            end
            if (k == 5) begin
                total++; if (ibus_rdt !== 32'h0000A5A5) $display("FAIL alt_ibus_rdt got %h exp 0000a5a5", ibus_rdt); else passed++;
            end
            if (k == 8) begin
                total++; if (dbus_rdt !== 32'h00100073) $display("FAIL alt_dbus_rdt got %h exp 00100073", dbus_rdt); else passed++;
            end
        end
        ibus_cyc = 1'b0;
        dbus_cyc = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_grant;
        ibus_adr = 32'h10;
        ibus_cyc = 1'b1;
        step();
        total++; if (ram_cyc !== 1'b1) $display("FAIL rstgnt_granted got cyc=%b exp 1", ram_cyc); else passed++;
        rst = 1'b1;
        #1;
        total++; if (ram_cyc !== 1'b0 || ibus_ack !== 1'b0) $display("FAIL rstgnt_forced got cyc=%b ack=%b exp 0 0", ram_cyc, ibus_ack); else passed++;
        step();
        total++; if (ibus_ack !== 1'b0) $display("FAIL rstgnt_no_ack got %b exp 0", ibus_ack); else passed++;
        rst = 1'b0;
        dbus_adr = 32'h20;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b1;
        step();
        total++; if (ram_cyc !== 1'b1 || ram_adr !== 6'd8) $display("FAIL rstgnt_tie_d got cyc=%b adr=%0d exp 1 8", ram_cyc, ram_adr); else passed++;
        step();
        total++; if (dbus_ack !== 1'b1 || ibus_ack !== 1'b0 || dbus_rdt !== 32'h00100073)
            $display("FAIL rstgnt_dbus_ack got d=%b i=%b rdt=%h exp 1 0 00100073", dbus_ack, ibus_ack, dbus_rdt);
        else passed++;
        ibus_cyc = 1'b0;
        dbus_cyc = 1'b0;
        step();
    endtask

    task automatic test_ack_in_idle;
        ack_force = 1'b1;
        #1;
        total++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) $display("FAIL idle_ack got %b%b exp 00", ibus_ack, dbus_ack); else passed++;
        step();
        total++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0 || ram_cyc !== 1'b0) $display("FAIL idle_ack_held got %b%b cyc=%b exp 00 0", ibus_ack, dbus_ack, ram_cyc); else passed++;
        ack_force = 1'b0;
        step();
    endtask

    task automatic test_timeout;
        int acks;
        ack_en   = 1'b0;
        dbus_adr = 32'h20;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b1;
`ifdef SERVANT_ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) begin
                total++; if ({ram_cyc, dbus_ack, timeout} !== 3'b100) $display("FAIL tmo_wait_c%0d got cyc/ack/tmo=%b exp 100", k, {ram_cyc, dbus_ack, timeout}); else passed++;
            end else begin
                total++; if ({ram_cyc, dbus_ack, timeout} !== 3'b011) $display("FAIL tmo_fire got cyc/ack/tmo=%b exp 011", {ram_cyc, dbus_ack, timeout}); else passed++;
                total++; if (dbus_rdt !== 32'h0 || ibus_rdt !== 32'h00100073) $display("FAIL tmo_rdt got d=%h i=%h exp 00000000 00100073", dbus_rdt, ibus_rdt); else passed++;
            end
        end
        dbus_cyc = 1'b0;
        step();
        total++; if (timeout !== 1'b0) $display("FAIL tmo_pulse got %b exp 0", timeout); else passed++;
`else
        acks = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (dbus_ack || timeout) acks++;
        end
        total++; if (acks !== 0) $display("FAIL notmo_no_ack got %0d exp 0", acks); else passed++;
        total++; if (ram_cyc !== 1'b1) $display("FAIL notmo_held got cyc=%b exp 1", ram_cyc); else passed++;
        dbus_cyc = 1'b0;
        step();
`endif
        ack_en = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8] = 32'h00100073;
        test_reset();
        test_ibus_read();
        test_dbus_write();
        test_abort();
        test_back_to_back();
        test_reset_mid_grant();
        test_ack_in_idle();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/servant_ram_arbiter.md
SERVANT_RAM_ARBITER -- requirements
Module: servant_ram_arbiter

Interface
REQ-001 SHALL have parameter aw, default 8, meaning RAM byte-address width; RAM word address is [aw-1:2].
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning maximum granted cycles without i_ram_ack (range 2..255).
REQ-003 SHALL have port i_wb_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_wb_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ibus ports: i_ibus_adr input 32; i_ibus_cyc input 1; o_ibus_rdt output 32; o_ibus_ack output 1. Ibus is read-only.
REQ-006 SHALL have dbus ports: i_dbus_adr input 32; i_dbus_dat input 32; i_dbus_sel input 4; i_dbus_we input 1; i_dbus_cyc input 1; o_dbus_rdt output 32; o_dbus_ack output 1.
REQ-007 SHALL have RAM ports: o_ram_adr output aw-2 (adr[aw-1:2] of granted master); o_ram_dat output 32; o_ram_sel output 4; o_ram_we output 1; o_ram_cyc output 1; i_ram_rdt input 32; i_ram_ack input 1.
REQ-008 SHALL have port o_timeout, output, 1, one-cycle pulse when a granted transfer is force-terminated.

Function
REQ-009 SHALL implement FSM states IDLE, GNT_I, GNT_D, plus a 1-bit last_grant register (0=ibus, 1=dbus).
REQ-010 IDLE: only ibus cyc -> GNT_I; only dbus cyc -> GNT_D; both -> grant master not equal to last_grant; neither -> stay IDLE.
REQ-011 On entering GNT_x, last_grant SHALL update to x.
REQ-012 o_ram_cyc SHALL equal (state==GNT_I & i_ibus_cyc) | (state==GNT_D & i_dbus_cyc), forced 0 while i_wb_rst is high.
REQ-013 o_ram_adr/dat/sel/we SHALL mux from granted master; in GNT_I and IDLE, o_ram_we=0, o_ram_sel=4'hF, o_ram_dat=0, o_ram_adr from ibus.
REQ-014 In GNT_x with i_ram_ack=1, o_x_ack SHALL be 1 the same cycle, o_x_rdt=i_ram_rdt, and next state IDLE.
REQ-015 o_x_ack SHALL never assert for the non-granted master or in IDLE; o_x_rdt SHALL be i_ram_rdt whenever o_x_ack=0 is irrelevant but deterministic (pass-through).
REQ-016 Latency: request seen in IDLE at cycle N -> o_ram_cyc at N+1 -> ack at N+2 with single-cycle-ack RAM; minimum back-to-back spacing 3 cycles per transfer.
REQ-017 Granted master dropping cyc before ack SHALL abort: next state IDLE, no ack issued, no RAM write (o_ram_cyc already low).
REQ-018 i_ram_ack received in IDLE SHALL be ignored.
REQ-019 Both requests continuously asserted SHALL alternate grants strictly I,D,I,D after first tie.

Reset
REQ-020 On i_wb_rst: state=IDLE, last_grant=0, timeout counter=0, o_timeout=0; o_ibus_ack=o_dbus_ack=o_ram_cyc=0 during and after the reset cycle.
REQ-021 Reset asserted mid-grant SHALL discard the transfer without ack; first arbitration after reset gives dbus priority on a tie.

Configuration
REQ-022 Macro SERVANT_ARB_TIMEOUT_EN SHALL compile in an 8-bit cycle counter, cleared in IDLE, incremented each GNT_x cycle without i_ram_ack.
REQ-023 With SERVANT_ARB_TIMEOUT_EN: when counter reaches TIMEOUT-1 and no i_ram_ack, that cycle o_x_ack=1, o_x_rdt=32'h0, o_ram_cyc=0, o_timeout=1, next state IDLE; ack on the same cycle takes precedence (normal ack, no o_timeout).
REQ-024 Without SERVANT_ARB_TIMEOUT_EN: no counter, grant held until ack or abort, o_timeout tied 0.

Verification
REQ-025 ibus only, adr=0x20, RAM word 8=0x00100073 -> o_ram_cyc at N+1, o_ibus_ack at N+2, o_ibus_rdt=0x00100073.
REQ-026 dbus write adr=0x10 dat=0xA5A5A5A5 sel=4'b0011, then ibus read 0x10 -> o_ibus_rdt=0x0000A5A5 (prior 0).
REQ-027 After reset, ibus and dbus cyc same cycle, held -> grants D,I,D,I; each master acked every 6 cycles.
REQ-028 dbus write granted, i_dbus_cyc dropped at first GNT_D cycle -> no o_dbus_ack, RAM word unchanged, FSM IDLE next.
REQ-029 With SERVANT_ARB_TIMEOUT_EN, TIMEOUT=4, i_ram_ack tied 0 -> o_dbus_ack=1, o_dbus_rdt=0, o_timeout=1 on 4th granted cycle; without macro, no ack after 100 cycles.
REQ-030 i_wb_rst pulsed during GNT_I -> o_ram_cyc=0 that cycle, no o_ibus_ack, then tie grants dbus first.
